// File: rtl/draw_pkg.sv
// ---------------------------------------------------------------------------
// draw_pkg
// Shared types and constants for the sprite draw scheduler slice.
//   draw_state_t : scheduler FSM states (IDLE, DRAW, GAP, FIN)
//   SCREEN_W/H   : VGA plot area (160 x 120)
//   X_W_DEF etc. : default coordinate/colour widths derived from the screen
// ---------------------------------------------------------------------------
package draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Narrowest coordinate widths that address the whole screen.
    localparam int X_W_DEF  = $clog2(SCREEN_W);
    localparam int Y_W_DEF  = $clog2(SCREEN_H);
    localparam int C_W_DEF  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        GAP  = 2'd2,
        FIN  = 2'd3
    } draw_state_t;

endpackage

// File: rtl/draw_next_sel.sv
// ---------------------------------------------------------------------------
// draw_next_sel
// Combinational priority finder for the next drawer to run.
//   mask    in  N      per-drawer active mask
//   cur_idx in  IDX_W  index of the drawer just finished
//   start   in  1      1: search from index 0, 0: search above cur_idx
//   nxt_idx out IDX_W  lowest qualifying index (0 when none)
//   found   out 1      a qualifying index exists
// ---------------------------------------------------------------------------
module draw_next_sel #(
    parameter int N     = 6,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] cur_idx,
    input  logic             start,
    output logic [IDX_W-1:0] nxt_idx,
    output logic             found
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        nxt_idx = '0;
        found   = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask[k] && (start || (k > int'(cur_idx)))) begin
                nxt_idx = k[IDX_W-1:0];
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// ---------------------------------------------------------------------------
// sprite_draw_scheduler
// Runs the sprite drawers one at a time onto the single VGA plot port.
// A frame_tick starts a pass; each selected drawer gets a draw level until it
// reports done, then one idle GAP cycle lets it drop done before the next.
//
// Ports
//   clk, reset (sync, active-low), abort (sync clear, same as reset)
//   frame_tick      : one-cycle pass request
//   active_i        : per-drawer enable mask (used with SKIP_INACTIVE_EN)
//   done_i          : per-drawer done level
//   x_i/y_i/colour_i: packed drawer pixel outputs, drawer k at [k*W +: W]
//   draw_o          : one-hot draw level to the running drawer
//   plot_o          : VGA write enable
//   vga_x/y/colour  : pixel of the drawer at idx
//   busy_o          : pass in progress
//   pass_done_o     : one-cycle pulse when a pass completes
//   overrun_o       : one-cycle pulse when frame_tick arrives mid-pass
//
// Build option
//   SKIP_INACTIVE_EN : when defined, drawers whose active_i bit is low are
//                      skipped; otherwise every drawer runs every pass.
// ---------------------------------------------------------------------------
module sprite_draw_scheduler
    import draw_pkg::*;
#(
    parameter int N_DRAWERS = 6,
    parameter int X_W       = X_W_DEF,
    parameter int Y_W       = Y_W_DEF,
    parameter int C_W       = C_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   abort,
    input  logic                   frame_tick,
    input  logic [N_DRAWERS-1:0]   active_i,
    input  logic [N_DRAWERS-1:0]   done_i,
    input  logic [N_DRAWERS*X_W-1:0] x_i,
    input  logic [N_DRAWERS*Y_W-1:0] y_i,
    input  logic [N_DRAWERS*C_W-1:0] colour_i,
    output logic [N_DRAWERS-1:0]   draw_o,
    output logic                   plot_o,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   busy_o,
    output logic                   pass_done_o,
    output logic                   overrun_o
);

    localparam int IDX_W = $clog2(N_DRAWERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DRAWERS - 1);

    draw_state_t      state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_found;
    logic             sel_start;
    logic             done_sel;

    assign sel_start = (state == IDLE);
    assign done_sel  = done_i[idx];

`ifdef SKIP_INACTIVE_EN
    draw_next_sel #(
        .N     (N_DRAWERS),
        .IDX_W (IDX_W)
    ) u_next_sel (
        .mask    (active_i),
        .cur_idx (idx),
        .start   (sel_start),
        .nxt_idx (sel_idx),
        .found   (sel_found)
    );
`else
    // Fixed order 0..N-1; the activity mask plays no part in this build.
    logic unused_active;
    assign unused_active = ^active_i;
    assign sel_idx   = sel_start ? '0 : idx + IDX_W'(1);
    assign sel_found = sel_start || (idx != LAST_IDX);
`endif

    function automatic logic [N_DRAWERS-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_DRAWERS'(1) << i;
    endfunction

    // Pixel mux follows idx; idx only moves in GAP/IDLE, so it is stable
    // across every plotted cycle of a drawer.
    always_comb begin
        vga_x      = x_i[0 +: X_W];
        vga_y      = y_i[0 +: Y_W];
        vga_colour = colour_i[0 +: C_W];
        for (int k = 0; k < N_DRAWERS; k++) begin
            if (idx == k[IDX_W-1:0]) begin
                vga_x      = x_i[k*X_W +: X_W];
                vga_y      = y_i[k*Y_W +: Y_W];
                vga_colour = colour_i[k*C_W +: C_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || abort) begin
            state       <= IDLE;
            idx         <= '0;
            draw_o      <= '0;
            plot_o      <= 1'b0;
            busy_o      <= 1'b0;
            pass_done_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            pass_done_o <= 1'b0;
            overrun_o   <= frame_tick && (state != IDLE);
            // Plot while drawing up to and including the done pixel; once
            // done is seen the drawer's further output is never written.
            plot_o      <= (state == DRAW) && !done_sel;

            case (state)
                IDLE: begin
                    if (frame_tick) begin
                        busy_o <= 1'b1;
                        if (sel_found) begin
                            state  <= DRAW;
                            idx    <= sel_idx;
                            draw_o <= onehot(sel_idx);
                        end else begin
                            state       <= FIN;
                            pass_done_o <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (done_sel) begin
                        state  <= GAP;
                        draw_o <= '0;
                    end
                end
                GAP: begin
                    if (sel_found) begin
                        state  <= DRAW;
                        idx    <= sel_idx;
                        draw_o <= onehot(sel_idx);
                    end else begin
                        state       <= FIN;
                        pass_done_o <= 1'b1;
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    draw_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
module tb_sprite_draw_scheduler;

    localparam int N    = 4;
    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;
    localparam int MAXC = 512;
`ifdef SKIP_INACTIVE_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic abort = 1'b0;
    logic frame_tick = 1'b0;
    logic [N-1:0] active_i = '1;
    logic [N-1:0] done_i;
    logic [N*X_W-1:0] x_i;
    logic [N*Y_W-1:0] y_i;
    logic [N*C_W-1:0] colour_i;
    logic [N-1:0] draw_o;
    logic plot_o, busy_o, pass_done_o, overrun_o;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;

    int errors = 0;
    int checks = 0;

    sprite_draw_scheduler #(
        .N_DRAWERS (N), .X_W (X_W), .Y_W (Y_W), .C_W (C_W)
    ) dut (
        .clk (clk), .reset (reset), .abort (abort), .frame_tick (frame_tick),
        .active_i (active_i), .done_i (done_i), .x_i (x_i), .y_i (y_i),
        .colour_i (colour_i), .draw_o (draw_o), .plot_o (plot_o),
        .vga_x (vga_x), .vga_y (vga_y), .vga_colour (vga_colour),
        .busy_o (busy_o), .pass_done_o (pass_done_o), .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;

    // Stub drawers: pixel counter p runs 1..len while draw is high, done at len
    // and held while draw stays high; dropping draw clears the drawer.
    logic [7:0] p   [N] = '{default: 8'd0};
    logic [7:0] len [N] = '{default: 8'd1};

    function automatic logic [X_W-1:0] xval(input int k, input int j);
        return X_W'(k * 40 + j * 3);
    endfunction
    function automatic logic [Y_W-1:0] yval(input int k, input int j);
        return Y_W'(k * 17 + j);
    endfunction
    function automatic logic [C_W-1:0] cval(input int k, input int j);
        return C_W'(k + j);
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (draw_o[k] !== 1'b1) p[k] <= 8'd0;
            else if (p[k] != len[k]) p[k] <= p[k] + 8'd1;
        end
    end

    always_comb begin
        done_i   = '0;
        x_i      = '0;
        y_i      = '0;
        colour_i = '0;
        for (int k = 0; k < N; k++) begin
            done_i[k]                = (p[k] == len[k]);
            x_i[k*X_W +: X_W]        = xval(k, int'(p[k]));
            y_i[k*Y_W +: Y_W]        = yval(k, int'(p[k]));
            colour_i[k*C_W +: C_W]   = cval(k, int'(p[k]));
        end
    end

    // Reference schedule, built from the pass timing rules: drawer with draw
    // rise c runs draw c..c+L, plots pixels 1..L at c+1..c+L, next rise c+L+2.
    logic [N-1:0] exp_draw [MAXC];
    bit           exp_plot [MAXC];
    int           exp_k    [MAXC];
    int           exp_pix  [MAXC];
    int           exp_T;
    int           exp_npix;

    task automatic build(input logic [N-1:0] act);
        int c;
        for (int t = 0; t < MAXC; t++) begin
            exp_draw[t] = '0; exp_plot[t] = 1'b0; exp_k[t] = 0; exp_pix[t] = 0;
        end
        c = 1;
        exp_npix = 0;
        for (int k = 0; k < N; k++) begin
            if (act[k] || !SKIP) begin
                for (int t = c; t <= c + int'(len[k]); t++) exp_draw[t] = N'(1) << k;
                for (int j = 1; j <= int'(len[k]); j++) begin
                    exp_plot[c + j] = 1'b1;
                    exp_k[c + j]    = k;
                    exp_pix[c + j]  = j;
                end
                exp_npix += int'(len[k]);
                c = c + int'(len[k]) + 2;
            end
        end
        exp_T = c;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One pass from a frame_tick issued in the current cycle (cycle 0).
    // tick2_at: extra frame_tick cycle; cut_at: cycle in which abort (kind 0)
    // or reset (kind 1) is applied; -1 disables either.
    task automatic run_pass(input logic [N-1:0] act, input int tick2_at,
                            input int cut_at, input int cut_kind, input string nm);
        int npl;
        logic [N-1:0] ed;
        bit ep, eb, ed_pd, eov;
        active_i = act;
        build(act);
        npl = 0;
        frame_tick = 1'b1;
        for (int t = 1; t <= exp_T + 2; t++) begin
            step();
            frame_tick = (t == tick2_at);
            if (t == cut_at) begin
                if (cut_kind == 0) abort = 1'b1;
                else begin reset = 1'b0; frame_tick = 1'b1; end
            end
            if (cut_at >= 0 && t == cut_at + 1) begin
                checks++;
                if ({draw_o, plot_o, busy_o, pass_done_o, overrun_o} !== '0) begin
                    errors++;
                    $display("FAIL %s cleared cycle %0d: got draw=%b plot=%b busy=%b pd=%b ov=%b want all 0",
                             nm, t, draw_o, plot_o, busy_o, pass_done_o, overrun_o);
                end
                if (cut_kind == 0) begin
                    abort = 1'b0;
                end else begin
                    step();
                    checks++;
                    if ({draw_o, plot_o, busy_o, pass_done_o, overrun_o} !== '0) begin
                        errors++;
                        $display("FAIL %s held_in_reset: got draw=%b plot=%b busy=%b want 0",
                                 nm, draw_o, plot_o, busy_o);
                    end
                    reset = 1'b1;
                    frame_tick = 1'b0;
                    step();
                    checks++;
                    if ({draw_o, busy_o, pass_done_o} !== '0) begin
                        errors++;
                        $display("FAIL %s idle_after_reset: got draw=%b busy=%b pd=%b want 0",
                                 nm, draw_o, busy_o, pass_done_o);
                    end
                end
                return;
            end
            ed    = (t <= exp_T) ? exp_draw[t] : '0;
            ep    = (t <= exp_T) ? exp_plot[t] : 1'b0;
            eb    = (t <= exp_T);
            ed_pd = (t == exp_T);
            eov   = (t == tick2_at + 1);
            checks++;
            if (draw_o !== ed) begin
                errors++;
                $display("FAIL %s draw_o cycle %0d: got %b want %b", nm, t, draw_o, ed);
            end
            checks++;
            if (plot_o !== ep) begin
                errors++;
                $display("FAIL %s plot_o cycle %0d: got %b want %b", nm, t, plot_o, ep);
            end
            checks++;
            if (busy_o !== eb) begin
                errors++;
                $display("FAIL %s busy_o cycle %0d: got %b want %b", nm, t, busy_o, eb);
            end
            checks++;
            if (pass_done_o !== ed_pd) begin
                errors++;
                $display("FAIL %s pass_done_o cycle %0d: got %b want %b", nm, t, pass_done_o, ed_pd);
            end
            checks++;
            if (overrun_o !== eov) begin
                errors++;
                $display("FAIL %s overrun_o cycle %0d: got %b want %b", nm, t, overrun_o, eov);
            end
            if (plot_o === 1'b1) npl++;
            if (ep) begin
                checks++;
                if ({vga_x, vga_y, vga_colour} !==
                    {xval(exp_k[t], exp_pix[t]), yval(exp_k[t], exp_pix[t]), cval(exp_k[t], exp_pix[t])}) begin
                    errors++;
                    $display("FAIL %s pixel cycle %0d: got x=%0d y=%0d c=%0d want drawer %0d pixel %0d",
                             nm, t, vga_x, vga_y, vga_colour, exp_k[t], exp_pix[t]);
                end
            end
        end
        checks++;
        if (npl != exp_npix) begin
            errors++;
            $display("FAIL %s plot_count: got %0d want %0d", nm, npl, exp_npix);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step(); step();
        checks++;
        if ({draw_o, plot_o, busy_o, pass_done_o, overrun_o} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got draw=%b plot=%b busy=%b pd=%b ov=%b want 0",
                     draw_o, plot_o, busy_o, pass_done_o, overrun_o);
        end
        checks++;
        if ({vga_x, vga_y, vga_colour} !== {xval(0, 0), yval(0, 0), cval(0, 0)}) begin
            errors++;
            $display("FAIL reset vga: got x=%0d y=%0d c=%0d want drawer 0 slice",
                     vga_x, vga_y, vga_colour);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int k = 0; k < N; k++) len[k] = 8'd20;
        run_pass('1, -1, -1, 0, "basic");
    endtask

    task automatic test_min_len();
        for (int k = 0; k < N; k++) len[k] = 8'd1;
        run_pass('1, -1, -1, 0, "min_len");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < N; k++) len[k] = 8'($urandom_range(1, 12));
            run_pass(N'($urandom_range(0, (1 << N) - 1)), -1, -1, 0, "random");
        end
    endtask

    task automatic test_skip_masks();
        for (int k = 0; k < N; k++) len[k] = 8'd20;
        run_pass(4'b1010, -1, -1, 0, "mask_1010");
        run_pass(4'b0000, -1, -1, 0, "mask_0000");
    endtask

    task automatic test_overrun();
        for (int k = 0; k < N; k++) len[k] = 8'd5;
        run_pass('1, 10, -1, 0, "overrun");
    endtask

    task automatic test_abort();
        for (int k = 0; k < N; k++) len[k] = 8'd6;
        run_pass('1, -1, 15, 0, "abort");
        run_pass('1, -1, -1, 0, "after_abort");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < N; k++) len[k] = 8'd9;
        run_pass('1, -1, 5, 1, "reset_mid");
        run_pass('1, -1, -1, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < N; k++) len[k] = 8'($urandom_range(1, 4));
        run_pass('1, -1, -1, 0, "b2b_first");
        run_pass('1, -1, -1, 0, "b2b_second");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_len();
        test_random();
        test_skip_masks();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Sequences N sprite drawers (enemies, player, bullets) onto the single shared VGA plot port. On each frame tick it starts one pass: it asserts each drawer's start/hold level in index order and waits for that drawer's done. It muxes the selected drawer's pixel coordinates and colour onto the VGA adapter and generates the plot strobe. It sits between the game FSM/datapath, which supplies the frame tick and activity mask, and the drawer instances such as the enemy drawers.

## Interface
- N_DRAWERS, 6, number of drawer clients (2..16)
- X_W, 8, x coordinate width
- Y_W, 7, y coordinate width
- C_W, 3, colour width (RGB)

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- abort  in  1  synchronous clear, same effect as reset (driven by space_pressed)
- frame_tick  in  1  one-cycle pulse requesting a draw pass
- active_i  in  N_DRAWERS  per-drawer enable mask (sampled at each selection)
- done_i  in  N_DRAWERS  per-drawer done level from drawers
- x_i  in  N_DRAWERS*X_W  packed drawer x outputs, drawer k at [k*X_W +: X_W]
- y_i  in  N_DRAWERS*Y_W  packed drawer y outputs
- colour_i  in  N_DRAWERS*C_W  packed drawer colour outputs
- draw_o  out  N_DRAWERS  one-hot (or zero) draw level to drawers
- plot_o  out  1  VGA write enable
- vga_x  out  X_W  selected x
- vga_y  out  Y_W  selected y
- vga_colour  out  C_W  selected colour
- busy_o  out  1  pass in progress
- pass_done_o  out  1  one-cycle pulse at pass end
- overrun_o  out  1  one-cycle pulse when frame_tick arrives while busy

## Operation
- States: IDLE, DRAW, GAP, FIN. Index register idx is log2(N_DRAWERS) bits wide.
- IDLE → DRAW on frame_tick. idx loads the first selected index, which is index 0 without the macro.
- DRAW: draw_o = one-hot(idx). On done_i[idx]=1 → GAP. Done is only honoured in DRAW, for the selected idx.
- GAP: draw_o = 0 for exactly one cycle, so the drawer clears its done. If a further index remains, idx loads it → DRAW. Otherwise → FIN.
- FIN: pass_done_o=1 for one cycle → IDLE.
- vga_x/vga_y/vga_colour: combinational mux of the drawer slice at idx, valid whenever plot_o=1.
- plot_o: registered. plot_o(t+1) = (state==DRAW) & ~done_i[idx](t). Each drawer's first pixel (one cycle after draw rises) through its last pixel (the cycle done rises) is plotted. A drawer restarting after done is never plotted.
- frame_tick outside IDLE is ignored, and overrun_o pulses on the next cycle.
- reset=0 or abort=1 at any edge (mid-pass included) forces: state IDLE, idx 0, draw_o 0, plot_o 0, busy_o 0, pass_done_o 0, overrun_o 0. abort has no priority over reset; both clear identically.
- busy_o = (state != IDLE), registered with the state.

## Timing
- All outputs are zero out of reset; vga_* reflect drawer 0 slice.
- frame_tick at cycle 0 → draw_o first asserted at cycle 1.
- A drawer of L pixels (done coincident with pixel L): pixels plotted at cycles c+1..c+L, where c is its draw rise. GAP falls at c+L+1, and the next draw rises at c+L+2. Cost per drawer is L+2 cycles.
- A full pass of D drawn drawers: pass_done_o at cycle 1 + D·(L+2).
- No deadlock guard: a drawer that never asserts done holds the pass until reset/abort.

## Configuration
- SKIP_INACTIVE_EN defined: index selection, both at the start of a pass and in GAP, picks the lowest index > current (or ≥0 at start) with active_i=1, in zero extra cycles.
  - If no index qualifies at frame_tick: IDLE → FIN → IDLE, with pass_done_o one cycle after the tick and no draw_o.
  - If no further index qualifies in GAP: → FIN.
- SKIP_INACTIVE_EN undefined: all N_DRAWERS are drawn every pass in order 0..N-1, and active_i is ignored.

## Structure
- Shared package draw_pkg:
  - state enum (IDLE/DRAW/GAP/FIN)
  - X_W/Y_W/C_W defaults
  - the screen-size constants 160/120
- Sub-module draw_next_sel: combinational priority finder returning the next index and a found flag, given mask, current idx and a start flag. It is instantiated only under SKIP_INACTIVE_EN.

## Test plan
- N=2, stub drawers of L=20 pixels. frame_tick at cycle 0 → draw_o=01 cycles 1–21, draw_o=10 cycles 23–43, pass_done_o at 45. Expect 40 plot_o pulses with coordinates matching each stub in turn.
- Drawer holds done high while draw stays asserted → no plot_o in the cycle after done, and draw_o drops at done+1.
- frame_tick repeated at cycle 10 of a pass → overrun_o at cycle 11, and pass timing unchanged.
- abort asserted at cycle 15 → cycle 16: draw_o=0, plot_o=0, busy_o=0. A new frame_tick then restarts from index 0.
- SKIP_INACTIVE_EN, N=4, active_i=1010 → only drawers 1 and 3 drawn, pass_done_o at 1+2·22=45. With active_i=0000 → pass_done_o at cycle 1, no draw_o.
- reset low mid-DRAW → all outputs zero next cycle, and frame_tick is ignored while reset is low.
